// File: rtl/id_opfetch_stage.sv
// id_opfetch_stage: IF->ID register, SRAM instruction hold and forwarded operand fetch.
// The load-use interlock is built only when ID_LOADUSE_STALL_EN is defined.
module id_opfetch_stage #(
   parameter int XLEN    = 32,
   parameter int RF_AW   = 5,
   parameter int NFWD    = 3,
   parameter int STALL_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [STALL_W-1:0]    i_stall,
   input  logic                  i_flush,
   input  logic                  i_if_valid,
   input  logic [XLEN-1:0]       i_if_pc,
   input  logic [31:0]           i_inst_rdata,
   input  logic                  i_use_rs,
   input  logic                  i_use_rt,
   input  logic [NFWD-1:0]       i_fwd_we,
   input  logic [NFWD*RF_AW-1:0] i_fwd_waddr,
   input  logic [NFWD*XLEN-1:0]  i_fwd_wdata,
   input  logic [NFWD-1:0]       i_fwd_is_load,
   input  logic [XLEN-1:0]       i_rf_rdata1,
   input  logic [XLEN-1:0]       i_rf_rdata2,
   output logic                  o_id_valid,
   output logic [XLEN-1:0]       o_id_pc,
   output logic [31:0]           o_id_inst,
   output logic [RF_AW-1:0]      o_rf_raddr1,
   output logic [RF_AW-1:0]      o_rf_raddr2,
   output logic [XLEN-1:0]       o_opnd1,
   output logic [XLEN-1:0]       o_opnd2,
   output logic                  o_stallreq
);
   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [31:0]     r_inst_hold;
   logic            r_hold_vld;
   logic            w_bubble;
   logic            w_unused;
   logic [RF_AW-1:0] w_a  [2];
   logic [XLEN-1:0]  w_rf [2];
   logic [XLEN-1:0]  w_op [2];
   logic             w_ld [2];
   assign w_bubble = i_flush | (i_stall[1] & ~i_stall[2]);
   always_ff @(posedge clk)
      if (rst || w_bubble) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
      end else if (!i_stall[1]) begin
         r_valid <= i_if_valid;
         r_pc    <= i_if_pc;
      end
   // SRAM data lives one cycle; capture it on the first held cycle so a long stall keeps the word.
   always_ff @(posedge clk)
      if (rst || w_bubble || !i_stall[1]) r_hold_vld <= 1'b0;
      else if (r_valid && !r_hold_vld) begin
         r_hold_vld  <= 1'b1;
         r_inst_hold <= i_inst_rdata;
      end
   assign o_id_valid  = r_valid;
   assign o_id_pc     = r_pc;
   assign o_id_inst   = !r_valid ? 32'h0 : r_hold_vld ? r_inst_hold : i_inst_rdata;
   assign o_rf_raddr1 = o_id_inst[21 +: RF_AW];
   assign o_rf_raddr2 = o_id_inst[16 +: RF_AW];
   assign w_a[0]  = o_rf_raddr1;
   assign w_a[1]  = o_rf_raddr2;
   assign w_rf[0] = i_rf_rdata1;
   assign w_rf[1] = i_rf_rdata2;
   // Scan from the oldest channel down so the youngest matching channel overwrites last.
   always_comb
      for (int k = 0; k < 2; k++) begin
         w_op[k] = w_rf[k];
         w_ld[k] = 1'b0;
         for (int i = NFWD - 1; i >= 0; i--)
            if (i_fwd_we[i] && i_fwd_waddr[i*RF_AW +: RF_AW] == w_a[k]) begin
               w_op[k] = i_fwd_wdata[i*XLEN +: XLEN];
               w_ld[k] = i_fwd_is_load[i];
            end
         if (!r_valid || w_a[k] == '0) begin
            w_op[k] = '0;
            w_ld[k] = 1'b0;
         end
      end
   assign o_opnd1 = w_op[0];
   assign o_opnd2 = w_op[1];
`ifdef ID_LOADUSE_STALL_EN
   assign o_stallreq = (i_use_rs & w_ld[0]) | (i_use_rt & w_ld[1]);
   assign w_unused   = ^i_stall;
`else
   assign o_stallreq = 1'b0;
   assign w_unused   = ^{i_stall, i_use_rs, i_use_rt, w_ld[0], w_ld[1]};
`endif
endmodule

// File: tb/tb_id_opfetch_stage.sv
// tb_id_opfetch_stage: directed stimulus with an expectation queue drained by a negedge monitor.
module tb_id_opfetch_stage;
`ifdef ID_LOADUSE_STALL_EN
   localparam bit LU = 1'b1;
`else
   localparam bit LU = 1'b0;
`endif
   typedef struct {
      string       name;
      logic        v;
      logic [31:0] pc, inst, o1, o2;
      logic        sr;
      bit          op;
   } exp_t;
   logic        clk = 1'b0, rst = 1'b1;
   logic [5:0]  stall = '0;
   logic        flush = 1'b0, if_valid = 1'b0, use_rs = 1'b0, use_rt = 1'b0;
   logic [31:0] if_pc = '0, inst_rdata = '0, rf1 = '0, rf2 = '0;
   logic [2:0]  fwe = '0, fld = '0;
   logic [14:0] fwa = '0;
   logic [95:0] fwd = '0;
   logic        id_valid, stallreq;
   logic [31:0] id_pc, id_inst, opnd1, opnd2;
   logic [4:0]  ra1, ra2;
   exp_t        q[$];
   int          checks = 0, errors = 0;
   always #5 clk = ~clk;
   id_opfetch_stage dut (
      .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush), .i_if_valid(if_valid),
      .i_if_pc(if_pc), .i_inst_rdata(inst_rdata), .i_use_rs(use_rs), .i_use_rt(use_rt),
      .i_fwd_we(fwe), .i_fwd_waddr(fwa), .i_fwd_wdata(fwd), .i_fwd_is_load(fld),
      .i_rf_rdata1(rf1), .i_rf_rdata2(rf2), .o_id_valid(id_valid), .o_id_pc(id_pc),
      .o_id_inst(id_inst), .o_rf_raddr1(ra1), .o_rf_raddr2(ra2), .o_opnd1(opnd1),
      .o_opnd2(opnd2), .o_stallreq(stallreq)
   );
   task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask
   always @(negedge clk)
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         cmp({e.name, ".valid"}, {31'h0, id_valid}, {31'h0, e.v});
         cmp({e.name, ".pc"}, id_pc, e.pc);
         cmp({e.name, ".inst"}, id_inst, e.inst);
         cmp({e.name, ".raddr"}, {22'h0, ra1, ra2}, {22'h0, e.inst[25:16]});
         cmp({e.name, ".stallreq"}, {31'h0, stallreq}, {31'h0, e.sr});
         if (e.op) begin
            cmp({e.name, ".opnd1"}, opnd1, e.o1);
            cmp({e.name, ".opnd2"}, opnd2, e.o2);
         end
      end
   task automatic expect_out(input string n, input logic v, input logic [31:0] pc, input logic [31:0] inst,
                             input logic [31:0] o1, input logic [31:0] o2, input logic sr);
      exp_t e;
      e = '{name: n, v: v, pc: pc, inst: inst, o1: o1, o2: o2, sr: sr, op: !sr};
      q.push_back(e);
   endtask
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   task automatic ch(input int i, input logic we, input logic [4:0] a, input logic [31:0] d, input logic ld);
      fwe[i] = we;
      fwa[i*5 +: 5] = a;
      fwd[i*32 +: 32] = d;
      fld[i] = ld;
   endtask
   initial begin
      cyc; cyc;
      expect_out("reset", 0, 0, 0, 0, 0, 0);
      cyc;
      rf1 = 32'hAAAA; rf2 = 32'hBBBB;
      ch(0, 1, 5'd0, 32'h9, 0);
      expect_out("reset_rf", 0, 0, 0, 0, 0, 0);
      cyc;
      ch(0, 0, 0, 0, 0);
      rst = 0; if_valid = 1; if_pc = 32'hBFC00000;
      cyc;
      inst_rdata = 32'h3C010001; if_pc = 32'hBFC00004;
      expect_out("fetch", 1, 32'hBFC00000, 32'h3C010001, 0, 32'hBBBB, 0);
      cyc;
      inst_rdata = 32'h00A60020;
      ch(0, 1, 5'd5, 32'h11, 0); ch(1, 1, 5'd5, 32'h22, 0); ch(2, 1, 5'd6, 32'h33, 0);
      expect_out("fwd_ch0", 1, 32'hBFC00004, 32'h00A60020, 32'h11, 32'h33, 0);
      cyc;
      fwe[0] = 0;
      expect_out("fwd_ch1", 1, 32'hBFC00004, 32'h00A60020, 32'h22, 32'h33, 0);
      cyc;
      fwe[1] = 0;
      expect_out("fwd_rf", 1, 32'hBFC00004, 32'h00A60020, 32'hAAAA, 32'h33, 0);
      cyc;
      ch(1, 1, 5'd6, 32'h44, 0);
      expect_out("fwd_ch1_over_ch2", 1, 32'hBFC00004, 32'h00A60020, 32'hAAAA, 32'h44, 0);
      cyc;
      inst_rdata = 32'h00000020;
      ch(0, 1, 5'd0, 32'hFFFF, 0); fwe[1] = 0; fwe[2] = 0;
      expect_out("x0", 1, 32'hBFC00004, 32'h00000020, 0, 0, 0);
      cyc;
      inst_rdata = 32'h00680020; use_rs = 1; use_rt = 1;
      ch(0, 1, 5'd8, 32'h77, 1);
      stall = 6'b000010;
      expect_out("loaduse", 1, 32'hBFC00004, 32'h00680020, 32'hAAAA, 32'h77, LU);
      cyc;
      expect_out("bubble", 0, 0, 0, 0, 0, 0);
      cyc;
      stall = 0; use_rs = 0; use_rt = 0; fwe = 0; fld = 0; if_pc = 32'hBFC00010;
      cyc;
      inst_rdata = 32'h8C880004; stall = 6'b000110;
      expect_out("hold0", 1, 32'hBFC00010, 32'h8C880004, 32'hAAAA, 32'hBBBB, 0);
      cyc;
      inst_rdata = 32'hDEADBEEF;
      for (int k = 1; k <= 3; k++) begin
         expect_out($sformatf("hold%0d", k), 1, 32'hBFC00010, 32'h8C880004, 32'hAAAA, 32'hBBBB, 0);
         cyc;
      end
      flush = 1;
      expect_out("hold_flush", 1, 32'hBFC00010, 32'h8C880004, 32'hAAAA, 32'hBBBB, 0);
      cyc;
      flush = 0;
      expect_out("flushed", 0, 0, 0, 0, 0, 0);
      cyc;
      stall = 0; if_pc = 32'hBFC00020;
      cyc;
      inst_rdata = 32'h00A60020;
      expect_out("after_flush", 1, 32'hBFC00020, 32'h00A60020, 32'hAAAA, 32'hBBBB, 0);
      stall = 6'b000110;
      cyc;
      inst_rdata = 32'hDEADBEEF;
      expect_out("hold_pre_rst", 1, 32'hBFC00020, 32'h00A60020, 32'hAAAA, 32'hBBBB, 0);
      rst = 1;
      cyc;
      expect_out("rst_in_stall", 0, 0, 0, 0, 0, 0);
      rst = 0; stall = 0; if_pc = 32'hBFC00030;
      cyc;
      inst_rdata = 32'h00000020;
      expect_out("after_rst", 1, 32'hBFC00030, 32'h00000020, 0, 0, 0);
      cyc;
      for (int k = 0; k < 10 && q.size() > 0; k++) cyc;
      if (q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
